// File: rtl/pe2_rr_arb_pkg.sv
// pe2_rr_arb_pkg: shared defaults and width helper for the round-robin multi-grant arbiter
package pe2_rr_arb_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NUM_GRANTS = 2;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/pe2_rr_arb_if.sv
// pe2_rr_arb_if: request/grant bundle between requestors (master) and the arbiter (slave)
interface pe2_rr_arb_if
  import pe2_rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_GRANTS = DEF_NUM_GRANTS
);
  localparam int IW = idx_w(WIDTH);
  localparam int CW = $clog2(NUM_GRANTS + 1);
  logic [WIDTH-1:0] req_vec;
  logic ack_ready;
  logic [NUM_GRANTS-1:0][WIDTH-1:0] grant_one_hot;
  logic [NUM_GRANTS-1:0][IW-1:0] grant_index;
  logic [NUM_GRANTS-1:0] grant_valid;
  logic [CW-1:0] grant_count;
  logic [WIDTH-1:0] grant_union;
  logic [IW-1:0] prio_ptr;
  modport master (
    output req_vec, ack_ready,
    input grant_one_hot, grant_index, grant_valid, grant_count, grant_union, prio_ptr
  );
  modport slave (
    input req_vec, ack_ready,
    output grant_one_hot, grant_index, grant_valid, grant_count, grant_union, prio_ptr
  );
endinterface

// File: rtl/pe2_rr_arb_pe_lsb.sv
// pe2_rr_arb_pe_lsb: combinational lowest-set-bit finder (one-hot, index, found)
module pe2_rr_arb_pe_lsb
  import pe2_rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0]        i_vec,
  output logic [WIDTH-1:0]        o_one_hot,
  output logic [idx_w(WIDTH)-1:0] o_index,
  output logic                    o_found
);
  localparam int IW = idx_w(WIDTH);
  assign o_one_hot = i_vec & (~i_vec + 1'b1);
  assign o_found = |i_vec;
  always_comb begin
    o_index = '0;
    for (int i = 0; i < WIDTH; i++) o_index = o_index | (o_one_hot[i] ? IW'(i) : '0);
  end
endmodule

// File: rtl/pe2_rr_arb.sv
// pe2_rr_arb: round-robin arbiter granting up to NUM_GRANTS requests per cycle from a rotating pointer
module pe2_rr_arb
  import pe2_rr_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NUM_GRANTS = DEF_NUM_GRANTS
) (
  input logic        CLK,
  input logic        nRST,
  pe2_rr_arb_if.slave bus
);
  localparam int IW = idx_w(WIDTH);
  localparam int CW = $clog2(NUM_GRANTS + 1);
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    w_last;
  logic [IW-1:0]    w_next_ptr;
  logic [CW-1:0]    w_count;
  logic [WIDTH-1:0] w_union;
  logic [WIDTH-1:0] w_v [NUM_GRANTS];
  logic [WIDTH-1:0] w_oh [NUM_GRANTS];
  logic [WIDTH-1:0] w_oh_out [NUM_GRANTS];
  logic [IW-1:0]    w_pos [NUM_GRANTS];
  logic [IW-1:0]    w_idx [NUM_GRANTS];
  logic [NUM_GRANTS-1:0] w_found;
  // rotate so the pointer position lands on bit 0
  assign w_v[0] = (bus.req_vec >> r_ptr) | (bus.req_vec << (WIDTH - int'(r_ptr)));
  for (genvar k = 0; k < NUM_GRANTS; k++) begin : g_stage
    logic [IW:0] w_sum;
    pe2_rr_arb_pe_lsb #(.WIDTH(WIDTH)) u_lsb (
      .i_vec     (w_v[k]),
      .o_one_hot (w_oh[k]),
      .o_index   (w_pos[k]),
      .o_found   (w_found[k])
    );
    if (k < NUM_GRANTS - 1) begin : g_next
      assign w_v[k+1] = w_v[k] & (w_v[k] - 1'b1);
    end
    assign w_oh_out[k] = (w_oh[k] << r_ptr) | (w_oh[k] >> (WIDTH - int'(r_ptr)));
    assign w_sum = {1'b0, w_pos[k]} + {1'b0, r_ptr};
    assign w_idx[k] = !w_found[k] ? '0 :
                      (w_sum >= (IW+1)'(WIDTH)) ? IW'(w_sum - (IW+1)'(WIDTH)) : IW'(w_sum);
  end
  always_comb begin
    w_count = '0;
    w_union = '0;
    w_last = '0;
    bus.grant_one_hot = '0;
    bus.grant_index = '0;
    for (int i = 0; i < NUM_GRANTS; i++) begin
      w_count = w_count + CW'(w_found[i]);
      w_union = w_union | w_oh_out[i];
      w_last = w_found[i] ? w_idx[i] : w_last;
      bus.grant_one_hot[i] = w_oh_out[i];
      bus.grant_index[i] = w_idx[i];
    end
  end
  assign w_next_ptr = (w_last == IW'(WIDTH - 1)) ? '0 : w_last + 1'b1;
  assign bus.grant_valid = w_found;
  assign bus.grant_count = w_count;
  assign bus.grant_union = w_union;
  assign bus.prio_ptr = r_ptr;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_ptr <= '0;
    else if (bus.ack_ready && w_found[0]) r_ptr <= w_next_ptr;
  end
endmodule

// File: tb/tb_pe2_rr_arb.sv
// tb_pe2_rr_arb: directed, exhaustive and random checks of pe2_rr_arb against a search-order model
module tb_pe2_rr_arb;
  localparam int G = 2;
  logic clk = 1'b0;
  logic nrst;
  int n_chk = 0;
  int n_err = 0;
  int mptr8 = 0;
  int mptr6 = 0;
  int e_cnt;
  int e_idx [G];
  logic [31:0] g_valid, g_cnt, g_idx0, g_idx1, g_oh0, g_oh1, g_union, g_ptr;

  pe2_rr_arb_if #(.WIDTH(8), .NUM_GRANTS(G)) b8 ();
  pe2_rr_arb_if #(.WIDTH(6), .NUM_GRANTS(G)) b6 ();
  pe2_rr_arb #(.WIDTH(8), .NUM_GRANTS(G)) u_dut8 (.CLK(clk), .nRST(nrst), .bus(b8));
  pe2_rr_arb #(.WIDTH(6), .NUM_GRANTS(G)) u_dut6 (.CLK(clk), .nRST(nrst), .bus(b6));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // walk the search order and hand out the first G set bits
  task automatic ref_model(input int w, input int req, input int ptr);
    int b;
    e_cnt = 0;
    for (int k = 0; k < G; k++) e_idx[k] = 0;
    for (int s = 0; s < w; s++) begin
      b = (ptr + s) % w;
      if (((req >> b) & 1) == 1 && e_cnt < G) begin
        e_idx[e_cnt] = b;
        e_cnt++;
      end
    end
  endtask

  task automatic sample(input int w);
    g_valid = (w == 8) ? 32'(b8.grant_valid) : 32'(b6.grant_valid);
    g_cnt   = (w == 8) ? 32'(b8.grant_count) : 32'(b6.grant_count);
    g_idx0  = (w == 8) ? 32'(b8.grant_index[0]) : 32'(b6.grant_index[0]);
    g_idx1  = (w == 8) ? 32'(b8.grant_index[1]) : 32'(b6.grant_index[1]);
    g_oh0   = (w == 8) ? 32'(b8.grant_one_hot[0]) : 32'(b6.grant_one_hot[0]);
    g_oh1   = (w == 8) ? 32'(b8.grant_one_hot[1]) : 32'(b6.grant_one_hot[1]);
    g_union = (w == 8) ? 32'(b8.grant_union) : 32'(b6.grant_union);
    g_ptr   = (w == 8) ? 32'(b8.prio_ptr) : 32'(b6.prio_ptr);
  endtask

  task automatic check_out(input int w);
    int req, eoh0, eoh1;
    req = (w == 8) ? int'(b8.req_vec) : int'(b6.req_vec);
    ref_model(w, req, (w == 8) ? mptr8 : mptr6);
    sample(w);
    eoh0 = (e_cnt > 0) ? (1 << e_idx[0]) : 0;
    eoh1 = (e_cnt > 1) ? (1 << e_idx[1]) : 0;
    chk($sformatf("w%0d_valid", w), g_valid, (1 << e_cnt) - 1);
    chk($sformatf("w%0d_count", w), g_cnt, e_cnt);
    chk($sformatf("w%0d_idx0", w), g_idx0, e_idx[0]);
    chk($sformatf("w%0d_idx1", w), g_idx1, e_idx[1]);
    chk($sformatf("w%0d_oh0", w), g_oh0, eoh0);
    chk($sformatf("w%0d_oh1", w), g_oh1, eoh1);
    chk($sformatf("w%0d_union", w), g_union, eoh0 | eoh1);
    chk($sformatf("w%0d_ptr", w), g_ptr, (w == 8) ? mptr8 : mptr6);
  endtask

  task automatic drive_check(input int w, input int req, input bit ack);
    @(negedge clk);
    if (w == 8) begin
      b8.req_vec = 8'(req);
      b8.ack_ready = ack;
      b6.ack_ready = 1'b0;
    end else begin
      b6.req_vec = 6'(req);
      b6.ack_ready = ack;
      b8.ack_ready = 1'b0;
    end
    #1 check_out(w);
  endtask

  task automatic clock_update(input int w);
    bit ack;
    ack = (w == 8) ? b8.ack_ready : b6.ack_ready;
    @(posedge clk);
    #1;
    if (ack && e_cnt > 0) begin
      if (w == 8) mptr8 = (e_idx[e_cnt-1] + 1) % w;
      else mptr6 = (e_idx[e_cnt-1] + 1) % w;
    end
    sample(w);
    chk($sformatf("w%0d_next_ptr", w), g_ptr, (w == 8) ? mptr8 : mptr6);
  endtask

  task automatic step(input int w, input int req, input bit ack);
    drive_check(w, req, ack);
    clock_update(w);
  endtask

  task automatic set_ptr(input int w, input int p);
    step(w, 1 << ((p + w - 1) % w), 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0;
    b8.req_vec = '0;
    b8.ack_ready = 1'b0;
    b6.req_vec = '0;
    b6.ack_ready = 1'b0;
    #6;
    check_out(8);
    check_out(6);
    nrst = 1'b1;
    step(8, 0, 1'b1);
    chk("reset_ptr_hold", g_ptr, 0);

    drive_check(8, 8'b01101000, 1'b1);
    chk("pair_idx0", g_idx0, 3);
    chk("pair_idx1", g_idx1, 5);
    chk("pair_union", g_union, 8'b00101000);
    clock_update(8);
    chk("pair_ptr", g_ptr, 6);

    drive_check(8, 8'b01000101, 1'b1);
    chk("wrap_idx0", g_idx0, 6);
    chk("wrap_idx1", g_idx1, 0);
    clock_update(8);
    chk("wrap_ptr", g_ptr, 1);

    for (int i = 0; i < 3; i++) begin
      drive_check(8, 8'hFF, 1'b0);
      chk("stall_idx0", g_idx0, 1);
      chk("stall_idx1", g_idx1, 2);
      clock_update(8);
      chk("stall_ptr", g_ptr, 1);
    end
    step(8, 8'hFF, 1'b1);
    chk("stall_release_ptr", g_ptr, 3);

    set_ptr(8, 1);
    drive_check(8, 8'b10000000, 1'b1);
    chk("single_idx0", g_idx0, 7);
    chk("single_valid", g_valid, 2'b01);
    chk("single_count", g_cnt, 1);
    clock_update(8);
    chk("single_ptr", g_ptr, 0);

    set_ptr(6, 4);
    drive_check(6, 6'b010001, 1'b1);
    chk("w6_idx0", g_idx0, 4);
    chk("w6_idx1", g_idx1, 0);
    clock_update(6);
    chk("w6_ptr", g_ptr, 1);

    set_ptr(8, 5);
    drive_check(8, 8'b00100001, 1'b0);
    chk("async_pre_idx0", g_idx0, 5);
    chk("async_pre_idx1", g_idx1, 0);
    #1 nrst = 1'b0;
    #1;
    mptr8 = 0;
    mptr6 = 0;
    check_out(8);
    chk("async_ptr", g_ptr, 0);
    chk("async_idx0", g_idx0, 0);
    chk("async_idx1", g_idx1, 5);
    #1 nrst = 1'b1;
    clock_update(8);

    for (int p = 0; p < 8; p++)
      for (int r = 0; r < 256; r++)
        for (int a = 0; a < 2; a++) begin
          set_ptr(8, p);
          step(8, r, a[0]);
        end

    for (int i = 0; i < 400; i++) begin
      step(8, int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      step(6, int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
